// File: rtl/pulse_period_monitor.sv
// -----------------------------------------------------------------------------
// pulse_period_monitor
//
// Watches an active-low periodic pulse line and measures the number of clk
// cycles between successive falling edges. Each measured period is checked
// against EXPECTED +/- TOL. After LOCK_COUNT consecutive in-window periods the
// monitor declares lock. A bad period while locked, or no edge for TIMEOUT
// cycles while acquiring or locked, is a loss event. Loss events set a sticky
// error flag that only clr_err clears.
//
// Ports:
//   clk           in   system clock, everything sampled on its rising edge
//   rst           in   synchronous reset, active-high
//   pulse_n       in   monitored active-low pulse line
//   clr_err       in   clears err_sticky (a loss event in the same cycle wins)
//   period        out  last measured period in clk cycles
//   period_valid  out  one-cycle strobe when period updates
//   locked        out  high while in LOCKED
//   lost          out  high while in LOST
//   err_sticky    out  set on any loss event, held until clr_err
//   match_cnt     out  consecutive in-window periods, saturates at 7
//
// Optional feature (compile-time macro PULSE_MON_SYNC_EN):
//   When defined, pulse_n passes through a 2-FF synchroniser (reset to 1)
//   before edge detection, so the pin may be asynchronous to clk. Edge
//   detection then lags the pin by 2 cycles; measured periods are unchanged.
//   When undefined, pulse_n must be synchronous to clk and is used directly.
//
// Handshake note: there is no back-pressure. period_valid is a pure strobe;
// a consumer must capture period in the cycle period_valid is high.
// -----------------------------------------------------------------------------
module pulse_period_monitor #(
    parameter int COUNT_WIDTH = 32,
    parameter int EXPECTED    = 10000,
    parameter int TOL         = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pulse_n,
    input  logic                   clr_err,
    output logic [COUNT_WIDTH-1:0] period,
    output logic                   period_valid,
    output logic                   locked,
    output logic                   lost,
    output logic                   err_sticky,
    output logic [2:0]             match_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT - 1);
    // Window bounds carry one extra bit so EXPECTED+TOL cannot wrap.
    localparam logic [COUNT_WIDTH:0]   WIN_LO       = (COUNT_WIDTH+1)'(EXPECTED - TOL);
    localparam logic [COUNT_WIDTH:0]   WIN_HI       = (COUNT_WIDTH+1)'(EXPECTED + TOL);
    localparam int unsigned            LOCK_TARGET  = LOCK_COUNT;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   prev_q, prev_d;
    logic [COUNT_WIDTH-1:0] period_q, period_d;
    logic                   period_valid_q, period_valid_d;
    logic                   locked_q, locked_d;
    logic                   lost_q, lost_d;
    logic                   err_q, err_d;
    logic [2:0]             match_q, match_d;

    logic                   cur;
    logic                   fall;
    logic [COUNT_WIDTH-1:0] captured;
    logic                   in_window;
    logic                   timeout_hit;
    logic                   loss_event;
    logic [2:0]             match_inc;

`ifdef PULSE_MON_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = pulse_n;
        sync2_d = sync1_q;
    end

    // Reset to 1 so a line idling high never produces a spurious fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign cur = sync2_q;
`else
    assign cur = pulse_n;
`endif

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        match_d        = match_q;
        loss_event     = 1'b0;

        fall   = prev_q && !cur;
        prev_d = cur;

        // The period ending on this fall includes the current cycle.
        captured  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        in_window = ({1'b0, captured} >= WIN_LO) && ({1'b0, captured} <= WIN_HI);

        if (fall) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // A fall in the same cycle always beats the timeout.
        timeout_hit = !fall && (cnt_q == TIMEOUT_LAST);
        match_inc   = (match_q == 3'd7) ? 3'd7 : match_q + 3'd1;

        case (state_q)
            // No reference edge yet: the first fall only starts a measurement.
            ST_IDLE, ST_LOST: begin
                if (fall) begin
                    state_d = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (fall) begin
                    period_d       = captured;
                    period_valid_d = 1'b1;
                    if (in_window) begin
                        match_d = match_inc;
                        if (32'(match_inc) >= LOCK_TARGET) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_d = 3'd0;
                    end
                end else if (timeout_hit) begin
                    state_d    = ST_LOST;
                    loss_event = 1'b1;
                    match_d    = 3'd0;
                end
            end
            ST_LOCKED: begin
                if (fall) begin
                    period_d       = captured;
                    period_valid_d = 1'b1;
                    if (in_window) begin
                        match_d = match_inc;
                    end else begin
                        state_d    = ST_LOST;
                        loss_event = 1'b1;
                        match_d    = 3'd0;
                    end
                end else if (timeout_hit) begin
                    state_d    = ST_LOST;
                    loss_event = 1'b1;
                    match_d    = 3'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new loss event takes priority over a clear in the same cycle.
        if (loss_event) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        locked_d = (state_d == ST_LOCKED);
        lost_d   = (state_d == ST_LOST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            prev_q         <= 1'b1;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            lost_q         <= 1'b0;
            err_q          <= 1'b0;
            match_q        <= 3'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prev_q         <= prev_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            lost_q         <= lost_d;
            err_q          <= err_d;
            match_q        <= match_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign lost         = lost_q;
    assign err_sticky   = err_q;
    assign match_cnt    = match_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_pulse_period_monitor
//
// Drives pulse trains with chosen and random periods into pulse_period_monitor
// (scaled parameters: EXPECTED=100, TOL=2, LOCK_COUNT=4, TIMEOUT=200) and
// compares every output on every cycle against a timestamp-based model of the
// monitor's rules. Literal checks at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_pulse_period_monitor;

    localparam int W      = 16;
    localparam int E      = 100;
    localparam int T      = 2;
    localparam int LOCK_N = 4;
    localparam int TO     = 200;
`ifdef PULSE_MON_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2, M_LOST = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pulse_n = 1'b1;
    logic         clr_err = 1'b0;
    logic [W-1:0] period;
    logic         period_valid;
    logic         locked;
    logic         lost;
    logic         err_sticky;
    logic [2:0]   match_cnt;

    pulse_period_monitor #(
        .COUNT_WIDTH(W),
        .EXPECTED   (E),
        .TOL        (T),
        .LOCK_COUNT (LOCK_N),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_n     (pulse_n),
        .clr_err     (clr_err),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .lost        (lost),
        .err_sticky  (err_sticky),
        .match_cnt   (match_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int  vectors     = 0;
    int  miscompares = 0;
    bit  reported    = 1'b0;
    bit  started     = 1'b0;
    bit  rnd_mode    = 1'b0;

    logic [W-1:0] exp_q[$];

    task automatic report();
        if (!reported) begin
            reported = 1'b1;
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
            if (miscompares > 200) begin
                report();
                $finish;
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the cycle number of the last accepted fall; a period is the
    // difference of two timestamps, a timeout is a timestamp distance.
    int cyc = 0;
    int m_last_fall = 0;
    int m_state = M_IDLE;
    int m_good = 0;
    int m_period = 0;
    bit m_pv = 1'b0;
    bit m_err = 1'b0;
    bit m_prev = 1'b1;
    bit h1 = 1'b1;
    bit h2 = 1'b1;

    function automatic bit in_window(input int p);
        return (p >= E - T) && (p <= E + T);
    endfunction

    always @(posedge clk) begin : model
        bit cur;
        bit fall;
        bit loss;
        int per;
        cyc = cyc + 1;
        if (rst) begin
            m_state = M_IDLE; m_good = 0; m_period = 0; m_pv = 1'b0;
            m_err = 1'b0; m_prev = 1'b1; h1 = 1'b1; h2 = 1'b1;
        end else begin
            if (SYNC_LAT == 2) begin
                cur = h2; h2 = h1; h1 = pulse_n;
            end else begin
                cur = pulse_n;
            end
            fall   = m_prev && !cur;
            m_prev = cur;
            m_pv   = 1'b0;
            loss   = 1'b0;
            if (fall) begin
                per = cyc - m_last_fall;
                m_last_fall = cyc;
                if (m_state == M_IDLE || m_state == M_LOST) begin
                    m_state = M_ACQ;
                end else begin
                    m_period = per;
                    m_pv     = 1'b1;
                    exp_q.push_back(W'(per));
                    if (in_window(per)) begin
                        m_good = (m_good < 7) ? m_good + 1 : 7;
                        if (m_state == M_ACQ && m_good >= LOCK_N) m_state = M_LOCKED;
                    end else begin
                        m_good = 0;
                        if (m_state == M_LOCKED) begin
                            m_state = M_LOST;
                            loss = 1'b1;
                        end
                    end
                end
            end else if ((m_state == M_ACQ || m_state == M_LOCKED) && (cyc - m_last_fall == TO)) begin
                m_state = M_LOST;
                loss    = 1'b1;
                m_good  = 0;
            end
            if (loss) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started) begin
            cmp("period",       32'(period),       32'(m_period));
            cmp("period_valid", 32'(period_valid), 32'(m_pv));
            cmp("locked",       32'(locked),       32'(m_state == M_LOCKED));
            cmp("lost",         32'(lost),         32'(m_state == M_LOST));
            cmp("err_sticky",   32'(err_sticky),   32'(m_err));
            cmp("match_cnt",    32'(match_cnt),    32'(m_good));
            if (period_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    cmp("sb_spurious_strobe", 32'(1), 32'(0));
                end else begin
                    cmp("sb_period", 32'(period), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One falling edge now, then per cycles until the next call can fall.
    task automatic edge_period(input int per, input bit clr_on_fall = 1'b0);
        int lo = $urandom_range(1, (per - 1 < 8) ? per - 1 : 8);
        int rst_at = (rnd_mode && $urandom_range(0, 99) == 0) ? int'($urandom_range(0, per - 1)) : -1;
        for (int i = 0; i < per; i++) begin
            pulse_n = (i < lo) ? 1'b0 : 1'b1;
            if (i == SYNC_LAT && clr_on_fall) clr_err = 1'b1;
            else clr_err = rnd_mode && ($urandom_range(0, 99) < 2);
            rst = (i == rst_at);
            cycle();
        end
        clr_err = 1'b0;
        rst = 1'b0;
    endtask

    function automatic int pick_period();
        int r = $urandom_range(0, 99);
        if (r < 70) return $urandom_range(E - T, E + T);
        else if (r < 90) return $urandom_range(E - 6, E + 6);
        else return $urandom_range(TO - 20, TO + 30);
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        miscompares++;
        report();
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; pulse_n = 1'b1; clr_err = 1'b0;
        cycle();
        started = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;

        // Idle line: never times out, stays at reset values.
        repeat (500) cycle();
        cmp("idle_period", 32'(period), 32'(0));
        cmp("idle_lost",   32'(lost),   32'(0));
        cmp("idle_locked", 32'(locked), 32'(0));

        // Lock on 5 edges of nominal period.
        repeat (5) edge_period(E);
        cmp("lock_locked", 32'(locked),    32'(1));
        cmp("lock_match",  32'(match_cnt), 32'(4));
        cmp("lock_period", 32'(period),    32'(E));
        cmp("model_lock_period", 32'(m_period), 32'(100));

        // One bad period of 103 while locked.
        edge_period(E + 3);
        edge_period(E);
        cmp("bad_lost",   32'(lost),       32'(1));
        cmp("bad_locked", 32'(locked),     32'(0));
        cmp("bad_period", 32'(period),     32'(103));
        cmp("bad_err",    32'(err_sticky), 32'(1));
        edge_period(E);
        cmp("reacq_lost",   32'(lost),   32'(0));
        cmp("reacq_period", 32'(period), 32'(103));

        // Relock, then stop pulses: loss exactly TIMEOUT cycles after last edge.
        repeat (4) edge_period(E);
        cmp("relock_locked", 32'(locked), 32'(1));
        repeat (E + SYNC_LAT) cycle();
        cmp("to_early_lost",   32'(lost),   32'(0));
        cmp("to_early_locked", 32'(locked), 32'(1));
        cycle();
        cmp("to_lost", 32'(lost),       32'(1));
        cmp("to_err",  32'(err_sticky), 32'(1));
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        cmp("clr_err",      32'(err_sticky), 32'(0));
        cmp("clr_keep_lost", 32'(lost),      32'(1));

        // Edge landing on the timeout cycle wins; 200 is out of window.
        // clr_err coincides with that loss event and must not win.
        repeat (5) edge_period(E);
        cmp("edge_to_locked", 32'(locked), 32'(1));
        edge_period(TO);
        edge_period(E, 1'b1);
        cmp("edge_to_period", 32'(period),     32'(200));
        cmp("edge_to_lost",   32'(lost),       32'(1));
        cmp("edge_to_err",    32'(err_sticky), 32'(1));

        // Window boundaries: 98 and 102 accepted, 97 rejected.
        edge_period(E);
        edge_period(E - 2);
        edge_period(E + 2);
        edge_period(E - 3);
        cmp("win_match3", 32'(match_cnt), 32'(3));
        edge_period(E);
        cmp("win_match0", 32'(match_cnt), 32'(0));
        cmp("win_period", 32'(period),    32'(97));
        cmp("win_locked", 32'(locked),    32'(0));

        // Randomised periods with random clr_err and occasional resets.
        rnd_mode = 1'b1;
        repeat (150) edge_period(pick_period());
        rnd_mode = 1'b0;

        // Reset in the middle of a locked measurement.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (5) edge_period(E);
        cmp("mid_locked_before", 32'(locked), 32'(1));
        repeat (49) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cmp("mid_period",    32'(period),       32'(0));
        cmp("mid_pv",        32'(period_valid), 32'(0));
        cmp("mid_locked",    32'(locked),       32'(0));
        cmp("mid_lost",      32'(lost),         32'(0));
        cmp("mid_err",       32'(err_sticky),   32'(0));
        cmp("mid_match",     32'(match_cnt),    32'(0));
        repeat (20) cycle();

        cmp("sb_queue_empty", 32'(exp_q.size()), 32'(0));
        report();
        $finish;
    end

endmodule
